// File: rtl/sorter_pkg.sv
// Shared defaults, FIFO entry type and FSM states for the sorter output drain.
package sorter_pkg;

  localparam int W_DEF = 8;
  localparam int N_DEF = 22;

  typedef struct packed {
    logic [W_DEF-1:0] data;
    logic             last;
  } drain_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } drain_state_t;

endpackage

// File: rtl/sorter_drain_fifo.sv
// Show-ahead FIFO for framed drain entries: the head entry is visible whenever not empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sorter_drain_fifo
  import sorter_pkg::*;
#(
  parameter type T     = drain_entry_t,
  parameter int  DEPTH = N_DEF,
  parameter int  AW    = $clog2(DEPTH),
  parameter int  NW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_push,
  input  T              i_wdat,
  input  logic          i_pop,
  output T              o_rdat,
  output logic          o_full,
  output logic          o_empty,
  output logic [NW-1:0] o_count
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [NW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_rdat  = r_mem[r_rd_ptr];
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wdat;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_rd) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sorter_drain.sv
// Captures the sorter's unstallable output burst, frames it with a last flag and replays it
// on valid/ready; checks descending order, reports batch length, flags overflow sticky.
module sorter_drain
  import sorter_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = N_DEF,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [W-1:0]  s_data,
  input  logic          s_valid,
  output logic [W-1:0]  m_data,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] batch_len,
  output logic          batch_done,
  output logic          order_err,
  output logic          ovf_err,
  input  logic          err_clr
);

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } entry_t;

  localparam int              NW      = $clog2(DEPTH + 1);
  localparam logic [NW-1:0]   CNT_MAX = NW'(DEPTH);
  localparam logic [CW-1:0]   LEN_SAT = '1;

  drain_state_t  r_state;
  logic [W-1:0]  r_hold_dat;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_batch_len;
  logic          r_batch_done;
  logic          r_order_err;
  logic          r_ovf_err;

  entry_t        w_wdat;
  entry_t        w_rdat;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  logic          w_order_set;
  logic [NW-1:0] w_count;

  // The held item is pushed every HOLD cycle; its last flag is the absence of a successor.
  assign w_push      = (r_state == HOLD);
  assign w_wdat      = '{data: r_hold_dat, last: !s_valid};
  assign w_pop       = !w_empty && m_ready;
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_order_set = w_push && s_valid && (s_data > r_hold_dat);

  sorter_drain_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .i_push  (w_push),
    .i_wdat  (w_wdat),
    .i_pop   (w_pop),
    .o_rdat  (w_rdat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign m_valid    = !w_empty;
  assign m_data     = w_rdat.data;
  assign m_last     = w_rdat.last;
  assign batch_len  = r_batch_len;
  assign batch_done = r_batch_done;
  assign order_err  = r_order_err;
  assign ovf_err    = r_ovf_err;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_hold_dat   <= '0;
      r_cnt        <= '0;
      r_batch_len  <= '0;
      r_batch_done <= 1'b0;
      r_order_err  <= 1'b0;
      r_ovf_err    <= 1'b0;
    end else begin
      r_batch_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_hold_dat <= s_data;
            r_cnt      <= CW'(1);
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (s_valid) begin
            r_hold_dat <= s_data;
            if (r_cnt != LEN_SAT) r_cnt <= r_cnt + CW'(1);
          end else begin
            r_batch_len  <= r_cnt;
            r_batch_done <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A new error in the clearing cycle wins over err_clr.
      if (w_order_set)  r_order_err <= 1'b1;
      else if (err_clr) r_order_err <= 1'b0;
      if (w_drop)       r_ovf_err   <= 1'b1;
      else if (err_clr) r_ovf_err   <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (!nreset) w_count <= CNT_MAX);

endmodule

// File: tb/tb_sorter_drain.sv
// Random and directed bursts into sorter_drain, checked against a queue model of the drain.
module tb_sorter_drain;

  localparam int DEPTH = 22;
  localparam int SAT   = 31;

  logic       clk;
  logic       nreset;
  logic [7:0] s_data;
  logic       s_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] batch_len;
  logic       batch_done;
  logic       order_err;
  logic       ovf_err;
  logic       err_clr;

  sorter_drain dut (
    .clk        (clk),
    .nreset     (nreset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .batch_len  (batch_len),
    .batch_done (batch_done),
    .order_err  (order_err),
    .ovf_err    (ovf_err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t sb[$];
  int   bq[$];

  // Reference state: the last sampled item waits until its successor (or a gap) is seen.
  logic       h_vld;
  logic [7:0] h_dat;
  int         h_cnt;
  int         x_len;
  logic       x_done;
  logic       x_oerr;
  logic       x_verr;

  int   n_chk;
  int   n_fail;
  logic rand_rdy;
  logic rand_clr;
  int   rdy_on_at;

  always @(posedge clk or negedge nreset) begin : model
    int   sz;
    logic oset;
    logic vset;
    logic done_n;
    if (!nreset) begin
      sb.delete();
      h_vld  <= 1'b0;
      h_dat  <= '0;
      h_cnt  <= 0;
      x_len  <= 0;
      x_done <= 1'b0;
      x_oerr <= 1'b0;
      x_verr <= 1'b0;
    end else begin
      oset   = 1'b0;
      vset   = 1'b0;
      done_n = 1'b0;
      sz     = sb.size();
      if (sz > 0 && m_ready) begin
        void'(sb.pop_front());
        sz = sz - 1;
      end
      if (h_vld) begin
        if (sz < DEPTH) sb.push_back('{d: h_dat, l: !s_valid});
        else            vset = 1'b1;
        if (!s_valid) begin
          x_len  <= h_cnt;
          done_n = 1'b1;
        end
      end
      if (s_valid) begin
        if (h_vld && s_data > h_dat) oset = 1'b1;
        h_cnt <= h_vld ? ((h_cnt >= SAT) ? SAT : h_cnt + 1) : 1;
        h_dat <= s_data;
      end
      h_vld  <= s_valid;
      x_done <= done_n;
      x_oerr <= oset ? 1'b1 : (err_clr ? 1'b0 : x_oerr);
      x_verr <= vset ? 1'b1 : (err_clr ? 1'b0 : x_verr);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    if (!nreset) begin
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_last", 32'(m_last), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_batch_len", 32'(batch_len), 0);
      check("rst_batch_done", 32'(batch_done), 0);
      check("rst_order_err", 32'(order_err), 0);
      check("rst_ovf_err", 32'(ovf_err), 0);
    end else begin
      check("m_valid", 32'(m_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("m_data", 32'(m_data), 32'(sb[0].d));
        check("m_last", 32'(m_last), 32'(sb[0].l));
      end
      check("batch_len", 32'(batch_len), 32'(x_len));
      check("batch_done", 32'(batch_done), 32'(x_done));
      check("order_err", 32'(order_err), 32'(x_oerr));
      check("ovf_err", 32'(ovf_err), 32'(x_verr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    err_clr = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic burst();
    for (int i = 0; i < bq.size(); i++) begin
      s_valid = 1'b1;
      s_data  = 8'(bq[i]);
      if (rdy_on_at >= 0) m_ready = (i >= rdy_on_at);
      step();
    end
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step();
  endtask

  initial begin
    int v;
    n_chk     = 0;
    n_fail    = 0;
    rand_rdy  = 1'b0;
    rand_clr  = 1'b0;
    rdy_on_at = -1;
    nreset    = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b1;
    err_clr   = 1'b0;
    #2 nreset = 1'b0;
    idle(3);
    nreset = 1'b1;
    idle(2);

    bq = '{9, 7, 7, 3};        burst(); idle(6);
    bq = '{5, 8, 2};           burst(); idle(6);
    pulse_clr();               idle(2);
    bq = '{4, 1};              burst(); idle(1);
    bq = '{6};                 burst(); idle(5);

    m_ready = 1'b0;
    bq.delete();
    for (int i = 0; i < 22; i++) bq.push_back(200 - i);
    burst(); idle(3);
    m_ready = 1'b1;            idle(26);

    m_ready = 1'b0;
    bq.delete();
    for (int i = 0; i < 23; i++) bq.push_back(230 - i);
    burst(); idle(3);
    m_ready = 1'b1;            idle(26);
    pulse_clr();               idle(2);

    m_ready = 1'b0;
    rdy_on_at = 23;
    bq.delete();
    for (int i = 0; i < 40; i++) bq.push_back(250 - 2 * i);
    burst();
    rdy_on_at = -1;
    m_ready = 1'b1;            idle(30);

    rand_rdy = 1'b1;
    rand_clr = 1'b1;
    for (int b = 0; b < 14; b++) begin
      bq.delete();
      v = $urandom_range(100, 255);
      for (int i = 0; i < int'($urandom_range(1, 30)); i++) begin
        if (b % 2 == 0) begin
          bq.push_back(v);
          v = (v > 10) ? v - int'($urandom_range(0, 10)) : v;
        end else begin
          bq.push_back(int'($urandom_range(0, 255)));
        end
      end
      burst();
      idle(int'($urandom_range(1, 6)));
    end
    rand_rdy = 1'b0;
    rand_clr = 1'b0;
    m_ready  = 1'b1;
    err_clr  = 1'b0;
    idle(40);

    bq = '{60, 50, 40, 30, 20, 10};
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(bq[i]);
      step();
    end
    s_data = 8'(bq[3]);
    #2 nreset = 1'b0;
    s_valid = 1'b0;
    idle(2);
    nreset  = 1'b1;
    m_ready = 1'b1;
    idle(1);
    bq = '{2, 1};              burst(); idle(8);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
